// File: rtl/mtl_touch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : mtl_touch_conditioner
// Purpose  : Averages, clips and debounces raw touch samples into one
//            press pulse per tap, with a release hold-off.
// Revision : 1.0
// ============================================================================
module mtl_touch_conditioner #(
    parameter int LOG2_AVG = 2,
    parameter int X_MAX    = 799,
    parameter int Y_MAX    = 479,
    parameter int TIMEOUT  = 330000,
    parameter int HOLDOFF  = 3300000
) (
    input  logic       CLK_33,
    input  logic       reset,
    input  logic       raw_valid,
    input  logic       raw_down,
    input  logic [9:0] raw_x,
    input  logic [8:0] raw_y,
    output logic [9:0] x_touch,
    output logic [8:0] y_touch,
    output logic       pulse_touch,
    output logic       touching,
    output logic       release_pulse
);

    localparam int AW_X = 10 + LOG2_AVG;
    localparam int AW_Y = 9 + LOG2_AVG;
    localparam int CW   = LOG2_AVG + 1;

    localparam logic [CW-1:0] c_AVG_N   = CW'(1 << LOG2_AVG);
    localparam logic [9:0]    c_X_LIM   = 10'(X_MAX);
    localparam logic [8:0]    c_Y_LIM   = 9'(Y_MAX);
    localparam logic [23:0]   c_TIMEOUT = 24'(TIMEOUT);
    localparam logic [23:0]   c_HOLDOFF = 24'(HOLDOFF);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_PRESSED = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW_X-1:0]   acc_x_q, acc_x_d;
    logic [AW_Y-1:0]   acc_y_q, acc_y_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [23:0]       idle_q, idle_d;
    logic [23:0]       hold_q, hold_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic              pulse_q, pulse_d;
    logic              rel_q, rel_d;
    logic              touch_q, touch_d;

    logic [AW_X-1:0]   w_sum_x;
    logic [AW_Y-1:0]   w_sum_y;
    logic [CW-1:0]     w_cnt_inc;
    logic [9:0]        w_avg_x, w_clip_x;
    logic [8:0]        w_avg_y, w_clip_y;
    logic              w_down, w_up, w_timeout;

    always_comb begin
        w_sum_x   = acc_x_q + AW_X'(raw_x);
        w_sum_y   = acc_y_q + AW_Y'(raw_y);
        w_cnt_inc = cnt_q + CW'(1);
        w_avg_x   = w_sum_x[AW_X-1:LOG2_AVG];
        w_avg_y   = w_sum_y[AW_Y-1:LOG2_AVG];
        w_clip_x  = (w_avg_x > c_X_LIM) ? c_X_LIM : w_avg_x;
        w_clip_y  = (w_avg_y > c_Y_LIM) ? c_Y_LIM : w_avg_y;
        w_down    = raw_valid && raw_down;
        w_up      = raw_valid && !raw_down;
        // A sample on the timeout cycle takes priority over the timeout.
        w_timeout = !raw_valid && (idle_q >= c_TIMEOUT);
    end

    always_comb begin
        if (raw_valid) begin
            idle_d = '0;
        end else if (idle_q == {24{1'b1}}) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + 24'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        x_d     = x_q;
        y_d     = y_q;
        pulse_d = 1'b0;
        rel_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_down) begin
                    acc_x_d = AW_X'(raw_x);
                    acc_y_d = AW_Y'(raw_y);
                    cnt_d   = CW'(1);
                    state_d = S_ARM;
                end
            end

            S_ARM, S_PRESSED: begin
                if (w_down) begin
                    if (w_cnt_inc == c_AVG_N) begin
                        x_d     = w_clip_x;
                        y_d     = w_clip_y;
                        pulse_d = (state_q == S_ARM);
                        acc_x_d = '0;
                        acc_y_d = '0;
                        cnt_d   = '0;
                        state_d = S_PRESSED;
                    end else begin
                        acc_x_d = w_sum_x;
                        acc_y_d = w_sum_y;
                        cnt_d   = w_cnt_inc;
                    end
                end else if (w_up || w_timeout) begin
                    acc_x_d = '0;
                    acc_y_d = '0;
                    cnt_d   = '0;
                    if (state_q == S_PRESSED) begin
                        rel_d   = 1'b1;
                        hold_d  = c_HOLDOFF;
                        state_d = S_HOLDOFF;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_HOLDOFF: begin
                // Leaving on the count of 1 re-enters IDLE exactly HOLDOFF cycles after release.
                if (hold_q <= 24'd1) begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 24'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        touch_d = (state_d == S_PRESSED);
    end

    always_ff @(posedge CLK_33) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_x_q <= '0;
            acc_y_q <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            hold_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pulse_q <= 1'b0;
            rel_q   <= 1'b0;
            touch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            hold_q  <= hold_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pulse_q <= pulse_d;
            rel_q   <= rel_d;
            touch_q <= touch_d;
        end
    end

    assign x_touch       = x_q;
    assign y_touch       = y_q;
    assign pulse_touch   = pulse_q;
    assign touching      = touch_q;
    assign release_pulse = rel_q;

endmodule
`default_nettype wire

// File: tb/tb_mtl_touch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtl_touch_conditioner
// Purpose  : Directed and randomized bench for mtl_touch_conditioner.
// Revision : 1.0
// ============================================================================
module tb_mtl_touch_conditioner;

    localparam int LOG2_AVG = 2;
    localparam int AVG_N    = 4;
    localparam int X_MAX    = 799;
    localparam int Y_MAX    = 479;
    localparam int TIMEOUT  = 100;
    localparam int HOLDOFF  = 50;

    localparam int M_IDLE    = 0;
    localparam int M_ARM     = 1;
    localparam int M_PRESSED = 2;
    localparam int M_HOLD    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_valid;
    logic       raw_down;
    logic [9:0] raw_x;
    logic [8:0] raw_y;
    logic [9:0] x_touch;
    logic [8:0] y_touch;
    logic       pulse_touch;
    logic       touching;
    logic       release_pulse;

    always #5 clk = ~clk;

    mtl_touch_conditioner #(
        .LOG2_AVG (LOG2_AVG),
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX),
        .TIMEOUT  (TIMEOUT),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .CLK_33        (clk),
        .reset         (reset),
        .raw_valid     (raw_valid),
        .raw_down      (raw_down),
        .raw_x         (raw_x),
        .raw_y         (raw_y),
        .x_touch       (x_touch),
        .y_touch       (y_touch),
        .pulse_touch   (pulse_touch),
        .touching      (touching),
        .release_pulse (release_pulse)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: pending burst kept as a list, hold-off as an end time.
    int         m_mode;
    int         q_x[$];
    int         q_y[$];
    int         idle_run;
    longint     edge_n = 0;
    longint     hold_end;
    logic       m_tmo;
    logic       model_live = 1'b0;
    logic [9:0] e_x;
    logic [8:0] e_y;
    logic       e_pulse, e_rel, e_touch;

    function automatic int avg_clip(input int q[$], input int lim);
        int s = 0;
        foreach (q[i]) s += q[i];
        s = s / AVG_N;
        return (s > lim) ? lim : s;
    endfunction

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (reset) begin
            m_mode = M_IDLE;
            q_x.delete();
            q_y.delete();
            idle_run = 0;
            e_x = '0; e_y = '0;
            e_pulse = 1'b0; e_rel = 1'b0; e_touch = 1'b0;
        end else begin
            m_tmo   = !raw_valid && (idle_run >= TIMEOUT);
            e_pulse = 1'b0;
            e_rel   = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (raw_valid && raw_down) begin
                        q_x.push_back(int'(raw_x));
                        q_y.push_back(int'(raw_y));
                        m_mode = M_ARM;
                    end
                end
                M_ARM, M_PRESSED: begin
                    if (raw_valid && raw_down) begin
                        q_x.push_back(int'(raw_x));
                        q_y.push_back(int'(raw_y));
                        if (q_x.size() == AVG_N) begin
                            e_x = 10'(avg_clip(q_x, X_MAX));
                            e_y = 9'(avg_clip(q_y, Y_MAX));
                            e_pulse = (m_mode == M_ARM);
                            m_mode  = M_PRESSED;
                            q_x.delete();
                            q_y.delete();
                        end
                    end else if ((raw_valid && !raw_down) || m_tmo) begin
                        q_x.delete();
                        q_y.delete();
                        if (m_mode == M_PRESSED) begin
                            e_rel    = 1'b1;
                            hold_end = edge_n + HOLDOFF;
                            m_mode   = M_HOLD;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                M_HOLD: begin
                    if (edge_n >= hold_end) m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
            idle_run = raw_valid ? 0 : idle_run + 1;
            e_touch  = (m_mode == M_PRESSED);
        end
    end

    typedef struct {
        string name;
        int    act;
        int    exp;
    } lit_t;

    lit_t lit_q[$];
    lit_t lit_cur;

    always @(negedge clk) begin
        while (lit_q.size() > 0) begin
            lit_cur = lit_q.pop_front();
            vectors++;
            if (lit_cur.act != lit_cur.exp) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d", lit_cur.name, lit_cur.act, lit_cur.exp);
            end
        end
        if (model_live) begin
            vectors++;
            if (x_touch !== e_x || y_touch !== e_y || pulse_touch !== e_pulse ||
                touching !== e_touch || release_pulse !== e_rel) begin
                errors++;
                $display("FAIL model t=%0t: dut x=%0d y=%0d pulse=%b touch=%b rel=%b, expected x=%0d y=%0d pulse=%b touch=%b rel=%b",
                         $time, x_touch, y_touch, pulse_touch, touching, release_pulse,
                         e_x, e_y, e_pulse, e_touch, e_rel);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        lit_t l;
        l.name = name;
        l.act  = act;
        l.exp  = exp;
        lit_q.push_back(l);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic d, input int x, input int y);
        raw_valid = 1'b1;
        raw_down  = d;
        raw_x     = 10'(x);
        raw_y     = 9'(y);
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
        raw_down  = 1'b0;
        raw_x     = '0;
        raw_y     = '0;
    endtask

    task automatic press4(input int x0, input int y0, input int step);
        for (int k = 0; k < 4; k++) send(1'b1, x0 + k * step, y0 + k * step);
    endtask

    initial begin
        reset     = 1'b1;
        raw_valid = 1'b0;
        raw_down  = 1'b0;
        raw_x     = '0;
        raw_y     = '0;
        @(posedge clk);
        #1;
        model_live = 1'b1;
        idle_cycles(1);
        lit("reset_x", int'(x_touch), 0);
        lit("reset_y", int'(y_touch), 0);
        lit("reset_flags", int'({pulse_touch, touching, release_pulse}), 0);
        reset = 1'b0;
        idle_cycles(2);

        // Aborted arm: no pulse, outputs untouched
        send(1'b1, 50, 60);
        send(1'b1, 52, 62);
        send(1'b0, 0, 0);
        lit("abort_pulse", int'(pulse_touch), 0);
        lit("abort_touch", int'(touching), 0);
        lit("abort_x", int'(x_touch), 0);
        idle_cycles(3);

        // Basic averaged press
        press4(100, 200, 2);
        lit("press_x", int'(x_touch), 103);
        lit("press_y", int'(y_touch), 203);
        lit("press_pulse", int'(pulse_touch), 1);
        lit("press_touch", int'(touching), 1);
        idle_cycles(1);
        lit("pulse_width", int'(pulse_touch), 0);
        send(1'b0, 0, 0);
        lit("rel_pulse", int'(release_pulse), 1);
        lit("rel_touch", int'(touching), 0);
        idle_cycles(1);
        lit("rel_width", int'(release_pulse), 0);
        idle_cycles(55);

        // Saturation, then an in-press update without a second pulse
        press4(1020, 500, 0);
        lit("sat_x", int'(x_touch), 799);
        lit("sat_y", int'(y_touch), 479);
        lit("sat_pulse", int'(pulse_touch), 1);
        press4(10, 20, 0);
        lit("upd_x", int'(x_touch), 10);
        lit("upd_y", int'(y_touch), 20);
        lit("upd_pulse", int'(pulse_touch), 0);
        send(1'b0, 0, 0);
        idle_cycles(55);

        // Hold-off rejects an early press, accepts a late one
        press4(100, 200, 2);
        send(1'b0, 0, 0);
        lit("ho_rel", int'(release_pulse), 1);
        idle_cycles(19);
        press4(400, 300, 0);
        lit("ho_early_pulse", int'(pulse_touch), 0);
        lit("ho_early_x", int'(x_touch), 103);
        idle_cycles(36);
        press4(400, 300, 0);
        lit("ho_late_pulse", int'(pulse_touch), 1);
        lit("ho_late_x", int'(x_touch), 400);

        // Release by timeout
        idle_cycles(100);
        lit("tmo_before", int'(release_pulse), 0);
        lit("tmo_touch_before", int'(touching), 1);
        idle_cycles(1);
        lit("tmo_rel", int'(release_pulse), 1);
        lit("tmo_touch", int'(touching), 0);
        idle_cycles(55);

        // Arm abort by timeout, then a fresh press
        send(1'b1, 7, 8);
        send(1'b1, 7, 8);
        send(1'b1, 7, 8);
        idle_cycles(101);
        lit("arm_tmo_touch", int'(touching), 0);
        press4(200, 100, 0);
        lit("arm_tmo_x", int'(x_touch), 200);
        lit("arm_tmo_pulse", int'(pulse_touch), 1);

        // Reset mid-press
        send(1'b1, 900, 450);
        send(1'b1, 900, 450);
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        lit("rst_x", int'(x_touch), 0);
        lit("rst_flags", int'({pulse_touch, touching, release_pulse}), 0);
        press4(300, 400, 0);
        lit("rst_press_x", int'(x_touch), 300);
        lit("rst_press_y", int'(y_touch), 400);
        lit("rst_press_pulse", int'(pulse_touch), 1);
        idle_cycles(2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                reset = 1'b1;
                idle_cycles(1);
                reset = 1'b0;
            end else if (r < 5) begin
                idle_cycles(int'($urandom_range(60, 130)));
            end else if (r < 60) begin
                send($urandom_range(0, 9) != 0, int'($urandom_range(0, 1023)),
                     int'($urandom_range(0, 511)));
            end else begin
                raw_x = 10'($urandom_range(0, 1023));
                raw_y = 9'($urandom_range(0, 511));
                raw_down = 1'($urandom_range(0, 1));
                idle_cycles(1);
                raw_down = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
